pipe_stall_ctrl: RTL and testbench

Pipeline stall/flush sequencer for the 5-stage RISC-V core. It sits downstream of the hazard detection unit and consumes its stall request together with the AXI-side instruction/data memory busy signals and the ID-stage branch decision. It produces per-stage register enables, the IF/ID flush, and the ID/EX bubble select. It also holds a branch redirect that resolves during a memory stall until the pipe can move, and flags memory stalls that exceed a watchdog limit.

---
 rtl/pipe_stall_ctrl_if.sv | 42 ++++
 rtl/pipe_stall_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// ============================================================================
// Module      : pipe_stall_ctrl_if
// Description : Hazard/memory-busy requests in, stage enables and flush/bubble
//               controls out, for the pipeline stall/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hz_stall;
    logic             im_busy;
    logic             dm_busy;
    logic             br_taken;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output hz_stall, im_busy, dm_busy, br_taken,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_bubble, stall_timeout,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  hz_stall, im_busy, dm_busy, br_taken,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_bubble, stall_timeout,
        output stall_cycles, flush_count
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module      : pipe_stall_ctrl
// Description : Stall/flush sequencer for the 5-stage core; defers a branch
//               redirect across memory stalls and flags over-long stalls.
//               Optional performance counters enabled by PIPE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_stall_ctrl_if.slave  bus
);

    localparam int              WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] C_WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_HOLD       = 2'd1,
        ST_FLUSH_PEND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;

    logic w_mem_stall;
    logic w_redirect;
    logic w_pc_en;
    logic w_if_id_en;
    logic w_back_en;
    logic w_flush;
    logic w_bubble;

    assign w_mem_stall = bus.im_busy | bus.dm_busy;
    // A branch decision is only trustworthy when ID is not itself hazarded.
    assign w_redirect  = bus.br_taken & ~bus.hz_stall;

    always_comb begin
        w_pc_en    = 1'b1;
        w_if_id_en = 1'b1;
        w_back_en  = 1'b1;
        w_flush    = 1'b0;
        w_bubble   = 1'b0;
        if (w_mem_stall) begin
            w_pc_en    = 1'b0;
            w_if_id_en = 1'b0;
            w_back_en  = 1'b0;
        end else if (state_q == ST_FLUSH_PEND) begin
            w_flush = 1'b1;
        end else if (bus.hz_stall) begin
            w_pc_en    = 1'b0;
            w_if_id_en = 1'b0;
            w_bubble   = 1'b1;
        end else if (bus.br_taken) begin
            w_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_mem_stall) begin
                    state_d = w_redirect ? ST_FLUSH_PEND : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_mem_stall) begin
                    state_d = ST_RUN;
                end else if (w_redirect) begin
                    state_d = ST_FLUSH_PEND;
                end
            end
            ST_FLUSH_PEND: begin
                if (!w_mem_stall) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Watchdog saturates at the limit so it cannot wrap back below it.
    always_comb begin
        if (!w_mem_stall) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == C_WD_LIMIT) begin
            wd_cnt_d = wd_cnt_q;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wd_cnt_d == C_WD_LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_en         = w_pc_en;
    assign bus.if_id_en      = w_if_id_en;
    assign bus.id_ex_en      = w_back_en;
    assign bus.ex_mem_en     = w_back_en;
    assign bus.mem_wb_en     = w_back_en;
    assign bus.if_id_flush   = w_flush;
    assign bus.id_ex_bubble  = w_bubble;
    assign bus.stall_timeout = timeout_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(!w_pc_en);
        flush_count_d  = flush_count_q + CNT_W'(w_flush);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module      : tb_pipe_stall_ctrl
// Description : Scoreboard bench for pipe_stall_ctrl against a cycle-level
//               behavioural model of the stall/flush rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

    localparam int C_TMO   = 4;
    localparam int C_CNT_W = 16;

    typedef struct packed {
        logic [4:0]         en;
        logic               flush;
        logic               bubble;
        logic               tmo;
        logic [C_CNT_W-1:0] sc;
        logic [C_CNT_W-1:0] fc;
    } exp_t;

    logic clk;
    logic rst;

    pipe_stall_ctrl_if #(.CNT_W(C_CNT_W)) bus ();

    pipe_stall_ctrl #(
        .TIMEOUT_CYCLES (C_TMO),
        .CNT_W          (C_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t expq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference state: whether a redirect is owed, length of current stall run.
    logic               m_pending;
    int                 m_run;
    logic               m_tmo;
    logic [C_CNT_W-1:0] m_sc;
    logic [C_CNT_W-1:0] m_fc;

    task automatic do_cycle(input logic r, input logic hz, input logic im,
                            input logic dm, input logic br);
        exp_t e;
        logic mem;
        @(posedge clk);
        #1;
        rst          = r;
        bus.hz_stall = hz;
        bus.im_busy  = im;
        bus.dm_busy  = dm;
        bus.br_taken = br;
        if (!r) begin
            m_pending = 1'b0;
            m_run     = 0;
            m_tmo     = 1'b0;
            m_sc      = '0;
            m_fc      = '0;
        end
        mem      = im | dm;
        e.tmo    = m_tmo;
        e.flush  = 1'b0;
        e.bubble = 1'b0;
        e.en     = 5'b11111;
        if (mem) begin
            e.en = 5'b00000;
        end else if (m_pending) begin
            e.flush = 1'b1;
        end else if (hz) begin
            e.en     = 5'b00111;
            e.bubble = 1'b1;
        end else if (br) begin
            e.flush = 1'b1;
        end
`ifdef PIPE_PERF_EN
        e.sc = m_sc;
        e.fc = m_fc;
`else
        e.sc = '0;
        e.fc = '0;
`endif
        expq.push_back(e);
        if (r) begin
            m_pending = mem ? (m_pending | (br & ~hz)) : 1'b0;
            m_run     = mem ? m_run + 1 : 0;
            if (m_run >= C_TMO) m_tmo = 1'b1;
            if (!e.en[4]) m_sc = m_sc + 1'b1;
            if (e.flush)  m_fc = m_fc + 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a.en     = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
            a.flush  = bus.if_id_flush;
            a.bubble = bus.id_ex_bubble;
            a.tmo    = bus.stall_timeout;
            a.sc     = bus.stall_cycles;
            a.fc     = bus.flush_count;
            n_vec++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got en=%b flush=%b bubble=%b tmo=%b sc=%0d fc=%0d, want en=%b flush=%b bubble=%b tmo=%b sc=%0d fc=%0d",
                         $time, a.en, a.flush, a.bubble, a.tmo, a.sc, a.fc,
                         e.en, e.flush, e.bubble, e.tmo, e.sc, e.fc);
            end
        end
    end

    initial begin
        rst          = 1'b0;
        bus.hz_stall = 1'b0;
        bus.im_busy  = 1'b0;
        bus.dm_busy  = 1'b0;
        bus.br_taken = 1'b0;

        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Data stall of 5 cycles, redirect arrives in the second.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1, (i == 1));
        idle(2);

        // Instruction stall with two redirect pulses: one flush on release.
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0, (i == 1) || (i == 3));
        idle(2);

        // Hazarded branch during a stall must not create a pending redirect.
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Watchdog: 6 stall cycles with a limit of 4; flag stays until reset.
        for (int i = 0; i < 6; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Staggered release: stall holds until both busies drop.
        do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Reset while a redirect is pending drops it.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            do_cycle(($urandom_range(0, 99) != 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0));
        end
        // Long stalls to exercise the watchdog under random traffic.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 7; i++) begin
                do_cycle(1'b1, ($urandom_range(0, 1) == 0), 1'b0, 1'b1,
                         ($urandom_range(0, 2) == 0));
            end
            idle(2);
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(2);

        @(negedge clk);
        #1;
        n_vec++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
